// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue path: select codes, queued op record,
// issue FSM states.
package fpu_pkg;

    typedef enum logic [4:0] {
        FADD      = 5'b00000,
        FSUB      = 5'b00001,
        FMUL      = 5'b00010,
        FDIV      = 5'b00011,
        FSQRT     = 5'b00100,
        FMIN      = 5'b00101,
        FMAX      = 5'b00110,
        FMADD     = 5'b00111,
        FMSUB     = 5'b01000,
        FNMADD    = 5'b01001,
        FEQ       = 5'b01010,
        FLT       = 5'b01011,
        FLE       = 5'b01100,
        FSGNJ     = 5'b01101,
        FSGNJN    = 5'b01110,
        FSGNJX    = 5'b01111,
        FCLASS    = 5'b10000,
        FMV_X_W   = 5'b10001,
        FMV_W_X   = 5'b10010,
        FNMSUB    = 5'b10011,
        FCVT_W_S  = 5'b10100,
        FCVT_WU_S = 5'b10101,
        FCVT_S_W  = 5'b10110,
        FCVT_S_WU = 5'b10111
    } fpu_sel_t;

    localparam logic [4:0]  FPU_SEL_IDLE = 5'b11111;
    localparam logic [31:0] CANON_NAN    = 32'h7fc00000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [2:0]  rm;
        logic [4:0]  sel;
        logic [4:0]  rd;
    } fp_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } issue_state_t;

endpackage

// File: rtl/fp_op_fifo.sv
// Power-of-two FIFO of decoded FP ops with synchronous flush; head is always visible on rdata_o.
module fp_op_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  fp_op_t                  wdata_i,
    output fp_op_t                  rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [$clog2(DEPTH):0]  count_next_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fp_op_t            mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push_i && !pop_i)      count_d = count_q + CntW'(1);
            else if (pop_i && !push_i) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o      = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign full_o       = (count_q == CntW'(DEPTH));
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/fpu_issue_queue.sv
// Queues decoded RV32F ops and issues them one at a time to the FPU, holding operands
// while it stalls and returning the result on a one-cycle writeback pulse.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    input  logic [2:0]  in_rm,
    input  logic [4:0]  in_sel,
    input  logic [4:0]  in_rd,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [31:0] fpu_c,
    output logic [2:0]  fpu_rm,
    output logic [4:0]  fpu_sel,
    input  logic        fpu_stall,
    input  logic [31:0] fpu_res,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned CntW  = $clog2(DEPTH) + 1;
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    issue_state_t     state_q, state_d;
    fp_op_t           iss_q, iss_d;
    fp_op_t           fifo_head, fifo_wdata;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             timeout_q, timeout_d;
    logic             in_ready_q;
    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [CntW-1:0]  count, count_next;

    assign push       = in_valid && in_ready_q && !fifo_full && !flush;
    assign fifo_wdata = '{a: in_a, b: in_b, c: in_c, rm: in_rm, sel: in_sel, rd: in_rd};

    fp_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (g_clk),
        .rst_i        (g_rst),
        .flush_i      (flush),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      (fifo_wdata),
        .rdata_o      (fifo_head),
        .count_o      (count),
        .count_next_o (count_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        iss_d      = iss_q;
        wait_d     = wait_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        timeout_d  = timeout_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    iss_d   = fifo_head;
                    state_d = ISSUE;
                end
            end
            // fpu_stall still describes the previous op here, so it is not sampled.
            ISSUE: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (!fpu_stall) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = iss_q.rd;
                    wb_data_d  = fpu_res;
                    state_d    = DONE;
                end else if (wait_q == WaitW'(MAX_WAIT - 1)) begin
                    timeout_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = iss_q.rd;
                    wb_data_d  = CANON_NAN;
                    state_d    = DONE;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            pop        = 1'b0;
            iss_d      = iss_q;
            wb_valid_d = 1'b0;
            wb_rd_d    = wb_rd_q;
            wb_data_d  = wb_data_q;
            timeout_d  = timeout_q;
        end
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state_q    <= IDLE;
            iss_q      <= '0;
            wait_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            timeout_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            iss_q      <= iss_d;
            wait_q     <= wait_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            timeout_q  <= timeout_d;
            in_ready_q <= (count_next < CntW'(DEPTH));
        end
    end

    assign in_ready    = in_ready_q;
    assign fpu_a       = iss_q.a;
    assign fpu_b       = iss_q.b;
    assign fpu_c       = iss_q.c;
    assign fpu_rm      = iss_q.rm;
    assign fpu_sel     = (state_q == ISSUE || state_q == WAIT) ? iss_q.sel : FPU_SEL_IDLE;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign busy        = (count != '0) || (state_q != IDLE);
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench: accepted ops feed a writeback scoreboard and an FPU stall model;
// a negedge monitor checks every wb_valid pulse and operand stability.
module tb_fpu_issue_queue;
    import fpu_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 64;

    logic        g_clk = 1'b0;
    logic        g_rst, flush, in_valid, in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [2:0]  in_rm;
    logic [4:0]  in_sel, in_rd;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic [2:0]  fpu_rm;
    logic [4:0]  fpu_sel;
    logic        fpu_stall = 1'b0;
    logic [31:0] fpu_res = 32'h0;
    logic        wb_valid, busy, timeout_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 g_clk = ~g_clk;

    fpu_issue_queue #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .g_clk       (g_clk),
        .g_rst       (g_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_rm       (in_rm),
        .in_sel      (in_sel),
        .in_rd       (in_rd),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_c       (fpu_c),
        .fpu_rm      (fpu_rm),
        .fpu_sel     (fpu_sel),
        .fpu_stall   (fpu_stall),
        .fpu_res     (fpu_res),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [31:0] res;
    } mdl_t;

    exp_t        exp_q[$];
    mdl_t        mdl_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cur_stall = 0;
    logic [31:0] cur_res = '0;
    logic [31:0] cur_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // An op is accepted at the coming posedge when these hold at the negedge before it.
    always @(negedge g_clk) begin
        if (!g_rst && in_valid && in_ready && !flush) begin
            exp_q.push_back('{in_rd, cur_exp});
            mdl_q.push_back('{in_sel, in_a, in_b, cur_stall, cur_res});
        end
    end

    // FPU model: stall for the op's programmed number of negedges after it appears.
    int rem = 0;
    bit active = 1'b0;
    always @(negedge g_clk) begin
        mdl_t m;
        if (g_rst || fpu_sel == FPU_SEL_IDLE) begin
            active = 1'b0;
            rem = 0;
            fpu_stall = 1'b0;
        end else if (!active) begin
            active = 1'b1;
            if (mdl_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL issue_unexpected: got sel %h required no issue", fpu_sel);
                rem = 0;
            end else begin
                m = mdl_q.pop_front();
                chk("issue_sel", 32'(fpu_sel), 32'(m.sel));
                chk("issue_a", fpu_a, m.a);
                chk("issue_b", fpu_b, m.b);
                rem = m.stall;
                fpu_res = m.res;
            end
            fpu_stall = (rem > 0);
        end else begin
            if (rem > 0) rem--;
            fpu_stall = (rem > 0);
        end
    end

    // Writeback scoreboard and operand-stability monitor.
    logic [4:0]  p_sel = FPU_SEL_IDLE;
    logic [31:0] p_a = '0, p_b = '0, p_c = '0;
    logic [2:0]  p_rm = '0;
    logic        p_wbv = 1'b0;
    always @(negedge g_clk) begin
        exp_t e;
        if (!g_rst) begin
            if (wb_valid) begin
                chk("wb_valid_pulse", 32'(p_wbv), 32'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got rd %0d data %h required no writeback",
                             wb_rd, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (fpu_sel != FPU_SEL_IDLE && p_sel != FPU_SEL_IDLE) begin
                chk("hold_sel", 32'(fpu_sel), 32'(p_sel));
                chk("hold_a", fpu_a, p_a);
                chk("hold_b", fpu_b, p_b);
                chk("hold_c", fpu_c, p_c);
                chk("hold_rm", 32'(fpu_rm), 32'(p_rm));
            end
        end
        p_sel = g_rst ? FPU_SEL_IDLE : fpu_sel;
        p_a   = fpu_a;
        p_b   = fpu_b;
        p_c   = fpu_c;
        p_rm  = fpu_rm;
        p_wbv = wb_valid && !g_rst;
    end

    task automatic drive(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int stall, input logic [31:0] res,
                         input logic [31:0] exp);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_a      = a;
        in_b      = b;
        in_c      = 32'h0;
        in_rm     = 3'b000;
        in_rd     = rd;
        cur_stall = stall;
        cur_res   = res;
        cur_exp   = exp;
    endtask

    // Returns 1ns after the posedge that accepted the op.
    task automatic push_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int stall, input logic [31:0] res,
                           input logic [31:0] exp);
        int k = 0;
        @(posedge g_clk);
        #1;
        drive(sel, a, b, rd, stall, res, exp);
        @(negedge g_clk);
        while (!in_ready && k < 200) begin
            @(negedge g_clk);
            k++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready 0 required 1");
        end
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts posedges until wb_valid is seen; returns at that negedge.
    task automatic wait_wb(input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(posedge g_clk);
            cyc++;
            @(negedge g_clk);
        end while (!wb_valid && cyc < maxc);
        if (!wb_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL wb_timeout: got no wb_valid in %0d cycles, required one", maxc);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge g_clk);
        while (busy && k < 200) begin
            @(negedge g_clk);
            k++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        g_rst    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_c     = '0;
        in_rm    = '0;
        in_sel   = '0;
        in_rd    = '0;
        @(negedge g_clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fpu_sel", 32'(fpu_sel), 32'h1f);
        chk("rst_fpu_a", fpu_a, 32'h0);
        chk("rst_fpu_rm", 32'(fpu_rm), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        @(posedge g_clk);
        #1 g_rst = 1'b0;

        // FADD 1.0 + 2.0 with a 4-cycle stall
        push_op(FADD, 32'h3f800000, 32'h40000000, 5'd5, 4, 32'h40400000, 32'h40400000);
        wait_wb(50, cyc);
        chk("fadd_latency", 32'(cyc), 32'd6);
        wait_idle();

        // FEQ 1.0 == 1.0, no stall
        push_op(FEQ, 32'h3f800000, 32'h3f800000, 5'd6, 0, 32'h00000001, 32'h00000001);
        wait_wb(50, cyc);
        chk("feq_latency", 32'(cyc), 32'd3);
        wait_idle();

        // Fill the queue behind a long-stalling op; D waits with in_valid high while full
        push_op(FMUL, 32'h40000000, 32'h40400000, 5'd7, 10, 32'h40c00000, 32'h40c00000);
        push_op(FSUB, 32'h40400000, 32'h3f800000, 5'd8, 0, 32'h40000000, 32'h40000000);
        push_op(FMIN, 32'h3f800000, 32'h40000000, 5'd15, 1, 32'h3f800000, 32'h3f800000);
        @(posedge g_clk);
        #1;
        drive(FMAX, 32'h3f800000, 32'h40000000, 5'd16, 0, 32'h40000000, 32'h40000000);
        @(negedge g_clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        wait_wb(50, cyc);
        chk("full_at_first_wb", 32'(in_ready), 32'd0);
        @(negedge g_clk);
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge g_clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("fill_drained", 32'(exp_q.size()), 32'd0);

        // Flush in WAIT with one op queued; a push in the flush cycle is dropped
        push_op(FDIV, 32'h40000000, 32'h3f800000, 5'd9, 20, 32'h40000000, 32'h40000000);
        push_op(FSQRT, 32'h40800000, 32'h0, 5'd10, 0, 32'h40000000, 32'h40000000);
        @(posedge g_clk);
        #1;
        flush = 1'b1;
        drive(FADD, 32'h3f800000, 32'h3f800000, 5'd20, 0, 32'h40000000, 32'h40000000);
        exp_q.delete();
        mdl_q.delete();
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge g_clk);
        chk("flush_fpu_sel", 32'(fpu_sel), 32'h1f);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge g_clk);
        push_op(FMV_X_W, 32'h40490fdb, 32'h0, 5'd11, 0, 32'h40490fdb, 32'h40490fdb);
        wait_wb(50, cyc);
        chk("post_flush_latency", 32'(cyc), 32'd3);
        wait_idle();

        // FPU never releases stall -> canonical NaN after MAX_WAIT cycles in WAIT
        push_op(FDIV, 32'h3f800000, 32'h0, 5'd12, 100000, 32'h12345678, CANON_NAN);
        wait_wb(200, cyc);
        chk("timeout_latency", 32'(cyc), 32'd66);
        chk("timeout_set", 32'(timeout_err), 32'd1);
        wait_idle();
        @(posedge g_clk);
        #1 flush = 1'b1;
        @(posedge g_clk);
        #1 flush = 1'b0;
        @(negedge g_clk);
        chk("timeout_after_flush", 32'(timeout_err), 32'd1);
        push_op(FSGNJ, 32'hbf800000, 32'h40000000, 5'd13, 2, 32'h3f800000, 32'h3f800000);
        wait_wb(50, cyc);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        wait_idle();

        // Asynchronous reset mid-WAIT
        push_op(FMUL, 32'h40400000, 32'h40400000, 5'd14, 30, 32'h41100000, 32'h41100000);
        repeat (3) @(posedge g_clk);
        #3;
        g_rst = 1'b1;
        exp_q.delete();
        mdl_q.delete();
        #1;
        chk("arst_fpu_sel", 32'(fpu_sel), 32'h1f);
        chk("arst_fpu_a", fpu_a, 32'h0);
        chk("arst_fpu_b", fpu_b, 32'h0);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        chk("arst_wb_data", wb_data, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_timeout", 32'(timeout_err), 32'd0);
        @(posedge g_clk);
        #2 g_rst = 1'b0;
        repeat (40) @(negedge g_clk);
        chk("arst_quiet_busy", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
- Upstream feeder for the execute-stage FPU.
- Buffers decoded RV32F operations from the ID/EX stage in a small FIFO, then issues one at a time.
- Holds operands and the select code stable while the FPU reports stall, then captures the result and presents it for writeback with its destination register.
- Hides the FPU's negedge-registered stall semantics from the rest of the pipeline behind a valid/ready handshake.

Parameters:
- DEPTH, 2, number of queued operations (power of two, 2..8)
- MAX_WAIT, 64, cycles in WAIT before an operation is declared hung

Ports:
- g_clk  in  1  global clock; all state updates on posedge
- g_rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush (branch/trap)
- in_valid  in  1  decoded FP op present
- in_ready  out  1  queue can accept an op this cycle
- in_a, in_b, in_c  in  32 each  source operands
- in_rm  in  3  rounding mode
- in_sel  in  5  FPU op select code
- in_rd  in  5  destination register
- fpu_a, fpu_b, fpu_c  out  32 each  operands to FPU
- fpu_rm  out  3  rounding mode to FPU
- fpu_sel  out  5  select to FPU; FPU_SEL_IDLE when nothing issued
- fpu_stall  in  1  FPU stall flag
- fpu_res  in  32  FPU result
- wb_valid  out  1  one-cycle pulse: result valid
- wb_rd  out  5  destination of the result
- wb_data  out  32  result value
- busy  out  1  queue non-empty or op in flight
- timeout_err  out  1  sticky; set when an op exceeds MAX_WAIT

Behaviour:
- Reset values (async, g_rst=1):
  - count=0, rd/wr pointers 0, state IDLE
  - in_ready=1, fpu_sel=FPU_SEL_IDLE, fpu_a/b/c=0, fpu_rm=0
  - wb_valid=0, wb_rd=0, wb_data=0, busy=0, timeout_err=0
- Push and in_ready:
  - Push on in_valid && in_ready.
  - in_ready = (count < DEPTH), registered; no pass-through path.
- Pop and simultaneous push/pop:
  - Pop occurs on the IDLE->ISSUE transition; the head entry is copied into the issue register driving fpu_*.
  - Push and pop in the same cycle leave count unchanged.
  - Push to a full queue is impossible by handshake. Assert in the bench that in_valid && !in_ready never writes.
- State IDLE:
  - fpu_sel=FPU_SEL_IDLE.
  - If count>0, pop and go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - fpu_* driven from the issue register; fpu_stall ignored, since it reflects the previous op until the next negedge.
  - Go to WAIT; wait counter cleared.
- State WAIT:
  - fpu_* held stable; wait counter increments each cycle.
  - On a posedge where fpu_stall==0: wb_data<=fpu_res, wb_rd<=issued rd, wb_valid<=1, go to DONE.
  - When the counter reaches MAX_WAIT: timeout_err<=1, wb_data<=32'h7fc00000, wb_valid<=1, go to DONE.
- State DONE (1 cycle):
  - fpu_sel=FPU_SEL_IDLE so the FPU resamples for the next op; wb_valid drops next cycle.
  - If count>0, pop and go to ISSUE; else go to IDLE.
- Latency and throughput:
  - Combinational FPU ops: push at cycle N, ISSUE N+1, WAIT N+2, wb_valid at N+3.
  - Multi-cycle ops add the stall duration.
  - Back-to-back throughput: one op per 3 cycles minimum.
- flush:
  - Empties the FIFO (count=0, pointers 0), forces state IDLE and fpu_sel=FPU_SEL_IDLE, and suppresses any wb_valid that would be generated that cycle.
  - If flush and push coincide, flush wins and the pushed op is dropped.
  - Does not clear timeout_err; only g_rst clears it.
- busy = (count!=0) || (state!=IDLE).
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset mid-operation: everything returns to reset values immediately; the FPU sees FPU_SEL_IDLE.

Decomposition:
- Shared package fpu_pkg:
  - fpu_sel_t enum of 5-bit select codes (FADD=00000 … FCVT_S_WU=10111)
  - FPU_SEL_IDLE=5'b11111
  - CANON_NAN=32'h7fc00000
  - fp_op_t struct {a,b,c,rm,sel,rd}
  - issue_state_t enum {IDLE,ISSUE,WAIT,DONE}
- Sub-module fp_op_fifo: parameterised DEPTH FIFO of fp_op_t with push/pop/flush, count, full/empty. The FSM and issue register stay in fpu_issue_queue.

Test Plan:
- FADD push (a=3f800000, b=40000000, sel=00000, rd=5); FPU model stalls 4 cycles, res=40400000 -> fpu_* stable through WAIT; wb_valid single pulse, wb_rd=5, wb_data=40400000.
- FEQ (sel=01010, a=b=3f800000), stall never asserted -> wb_valid 3 cycles after push, wb_data=00000001.
- Fill DEPTH=2 queue while the first op stalls 10 cycles -> in_ready=0 after 2 pushes; ops retire in order; in_ready rises the cycle after the first pop.
- Flush while in WAIT with 1 queued op -> no wb_valid; fpu_sel=11111 next cycle; busy=0; a subsequent push issues normally.
- FPU model holds stall forever -> after MAX_WAIT=64 cycles in WAIT: wb_valid, wb_data=7fc00000, timeout_err=1 and sticky until g_rst.
- Assert g_rst asynchronously mid-WAIT (between clock edges) -> all outputs at reset values immediately; no wb_valid after release.
